// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg -- shared definitions for the PS/2 host transmit path.
//   txState_t                : transmitter state encoding
//   CMD_SET_LEDS / CMD_RESET : host commands (0xED, 0xFF)
//   RESP_ACK                 : device acknowledge byte (0xFA)
//   DEFAULT_*                : default timing / filter parameters at 50 MHz
//   oddParity()              : odd-parity bit for a data byte
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    PARITY,
    ACK,
    WAIT_IDLE,
    DONE
  } txState_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  localparam int unsigned DEFAULT_INHIBIT_CYCLES = 5000;    // 100 us
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 750000;  // 15 ms
  localparam int unsigned DEFAULT_FILTER_DEPTH   = 8;

  function automatic logic oddParity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter -- glitch filter and falling-edge detector for one PS/2 line.
//   Clock   in  system clock
//   Reset   in  asynchronous, active-high; line presets to idle-high
//   iRaw    in  raw pin level
//   oLevel  out filtered level: 1 after FILTER_DEPTH ones, 0 after FILTER_DEPTH zeros
//   oFall   out one-cycle pulse, the cycle after oLevel goes 1 -> 0
// Shared with the receive path.
module ps2_line_filter #(
  parameter int unsigned FILTER_DEPTH = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iRaw,
  output logic oLevel,
  output logic oFall
);

  logic [FILTER_DEPTH-1:0] shiftReg;
  logic [FILTER_DEPTH-1:0] shiftNext;
  logic                    levelPrev;

  assign shiftNext = {shiftReg[FILTER_DEPTH-2:0], iRaw};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shiftReg  <= '1;
      oLevel    <= 1'b1;
      levelPrev <= 1'b1;
      oFall     <= 1'b0;
    end else begin
      shiftReg <= shiftNext;
      if (&shiftNext) begin
        oLevel <= 1'b1;
      end else if (~|shiftNext) begin
        oLevel <= 1'b0;
      end
      levelPrev <= oLevel;
      oFall     <= levelPrev & ~oLevel;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter.
//   Clock, Reset        system clock; asynchronous active-high reset
//   iData, iSend        byte to send and start request (accepted in IDLE only)
//   iPs2Clk, iPs2Data   raw PS/2 pin levels
//   oPs2ClkDriveLow     1 = pull PS2_CLK low (open drain)
//   oPs2DataDriveLow    1 = pull PS2_DATA low (open drain)
//   oBusy, oRxInhibit   transfer in progress (identical)
//   oDone, oError       one-cycle end-of-transfer pulse; error on NACK/timeout
// Build option: define PS2_TX_TIMEOUT_EN to enable the device-clock watchdog.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_DEPTH   = DEFAULT_FILTER_DEPTH
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iSend,
  input  logic       iPs2Clk,
  input  logic       iPs2Data,
  output logic       oPs2ClkDriveLow,
  output logic       oPs2DataDriveLow,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic       oRxInhibit
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);

  txState_t         state;
  logic [7:0]       shiftReg;
  logic             parityBit;
  logic             nack;
  logic [INH_W-1:0] inhCnt;
  logic [3:0]       edgeCnt;

  logic clkLevel;
  logic clkFall;
  logic dataLevel;
  logic unusedDataFall;  // data-line edges play no part in transmitting

  ps2_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) uClkFilter (
    .Clock  (Clock),
    .Reset  (Reset),
    .iRaw   (iPs2Clk),
    .oLevel (clkLevel),
    .oFall  (clkFall)
  );

  ps2_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) uDataFilter (
    .Clock  (Clock),
    .Reset  (Reset),
    .iRaw   (iPs2Data),
    .oLevel (dataLevel),
    .oFall  (unusedDataFall)
  );

  assign oRxInhibit = oBusy;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdCnt;
  logic            wdActive;
  logic            wdExpired;

  assign wdActive  = state inside {RTS, DATA, PARITY, ACK, WAIT_IDLE};
  assign wdExpired = wdActive && (wdCnt == WD_LAST);

  // Held at zero through INHIBIT so the count starts fresh on entry to RTS.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wdCnt <= '0;
    end else if (!wdActive || clkFall) begin
      wdCnt <= '0;
    end else if (!wdExpired) begin
      wdCnt <= wdCnt + WD_W'(1);
    end
  end
`else
  logic unusedTimeoutCfg;  // parameter list stays identical in both builds
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      shiftReg         <= '0;
      parityBit        <= 1'b0;
      nack             <= 1'b0;
      inhCnt           <= '0;
      edgeCnt          <= '0;
      oPs2ClkDriveLow  <= 1'b0;
      oPs2DataDriveLow <= 1'b0;
      oBusy            <= 1'b0;
      oDone            <= 1'b0;
      oError           <= 1'b0;
    end else begin
      oDone  <= 1'b0;
      oError <= 1'b0;
      case (state)
        IDLE: begin
          if (iSend) begin
            shiftReg        <= iData;
            parityBit       <= oddParity(iData);
            nack            <= 1'b0;
            inhCnt          <= '0;
            oPs2ClkDriveLow <= 1'b1;
            oBusy           <= 1'b1;
            state           <= INHIBIT;
          end
        end
        INHIBIT: begin
          inhCnt <= inhCnt + INH_W'(1);
          // Data goes low one cycle before clock release: the start bit.
          if (inhCnt == INH_DATA) begin
            oPs2DataDriveLow <= 1'b1;
          end
          if (inhCnt == INH_LAST) begin
            oPs2ClkDriveLow <= 1'b0;
            edgeCnt         <= '0;
            state           <= RTS;
          end
        end
        RTS: begin
          if (clkFall) begin
            edgeCnt          <= 4'd1;
            oPs2DataDriveLow <= ~shiftReg[0];
            shiftReg         <= shiftReg >> 1;
            state            <= DATA;
          end
        end
        DATA: begin
          if (clkFall) begin
            edgeCnt <= edgeCnt + 4'd1;
            if (edgeCnt == 4'd8) begin
              oPs2DataDriveLow <= ~parityBit;
              state            <= PARITY;
            end else begin
              oPs2DataDriveLow <= ~shiftReg[0];
              shiftReg         <= shiftReg >> 1;
            end
          end
        end
        PARITY: begin
          if (clkFall) begin
            edgeCnt          <= edgeCnt + 4'd1;
            oPs2DataDriveLow <= 1'b0;
            state            <= ACK;
          end
        end
        ACK: begin
          if (clkFall) begin
            edgeCnt <= edgeCnt + 4'd1;
            nack    <= dataLevel;
            state   <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clkLevel && dataLevel) begin
            oDone  <= 1'b1;
            oError <= nack;
            oBusy  <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Overrides whatever the active state decided this cycle.
      if (wdExpired) begin
        oPs2ClkDriveLow  <= 1'b0;
        oPs2DataDriveLow <= 1'b0;
        oBusy            <= 1'b0;
        oDone            <= 1'b1;
        oError           <= 1'b1;
        state            <= DONE;
      end
`endif
    end
  end

endmodule
